candy_regfile_mp: RTL and testbench
===================================

CANDY_REGFILE_MP -- requirements
Module: candy_regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports, legal 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports we0/we1  input  1 each  write enables, port 0 and port 1.
REQ-008 SHALL have ports waddr0/waddr1  input  ADDR_W each  write addresses.
REQ-009 SHALL have ports wdata0/wdata1  input  DATA_W each  write data.
REQ-010 SHALL have port re  input  NUM_RD  per-port read enable, bit i = port i.
REQ-011 SHALL have port raddr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rdata  output  NUM_RD*DATA_W  registered read data, port i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port rbusy  output  NUM_RD  registered scoreboard busy flag per read port.
REQ-014 SHALL have port sb_set  input  1  mark register sb_addr busy (pending write issued).
REQ-015 SHALL have port sb_addr  input  ADDR_W  scoreboard set address.

Function
REQ-016 SHALL write wdataN into register waddrN at the clock edge when weN=1.
REQ-017 SHALL, when we0=we1=1 and waddr0=waddr1, store wdata1 (port 1 priority).
REQ-018 SHALL, when ZERO_REG=1, ignore writes to address 0 and return 0 on reads of address 0.
REQ-019 SHALL register reads: rdata port i at edge k reflects raddr/re sampled at edge k; one-cycle latency.
REQ-020 SHALL forward same-cycle writes: raddr_i matching an active write returns that write's data (wdata1 over wdata0), not the stale array value.
REQ-021 SHALL drive rdata_i and rbusy_i to 0 at the edge when re_i=0.
REQ-022 SHALL keep one busy bit per register; sb_set=1 sets busy[sb_addr]; weN=1 clears busy[waddrN].
REQ-023 SHALL give set priority over clear when sb_set and a write target the same address in one cycle.
REQ-024 SHALL never set busy[0] when ZERO_REG=1.
REQ-025 SHALL load rbusy_i with the post-update busy value of raddr_i (same-cycle set and clear applied, per REQ-023).
REQ-026 SHALL handle all NUM_RD ports independently; identical addresses on multiple ports return identical data.
REQ-027 SHALL hold rdata and rbusy between edges; no combinational path from inputs to outputs.

Reset
REQ-028 SHALL, on clk edge with rst=1, clear all registers to 0, all busy bits to 0, all rdata to 0, all rbusy to 0.
REQ-029 SHALL ignore writes, sb_set and reads in any cycle with rst=1; reset mid-operation discards them.
REQ-030 SHALL resume normal operation on the first edge with rst=0.

Verification
REQ-031 SHALL cover: reset, then re=2'b11, raddr={5'd3,5'd1} -> rdata all 0, rbusy 0.
REQ-032 SHALL cover: we0=1 waddr0=5 wdata0=0xDEADBEEF with re[0]=1 raddr0=5 same cycle -> rdata0=0xDEADBEEF next cycle; next-cycle read of 5 also 0xDEADBEEF.
REQ-033 SHALL cover: we0=we1=1, both to address 7, wdata0=0x11, wdata1=0x22 -> later read of 7 returns 0x22.
REQ-034 SHALL cover: write 0x55 to address 0 with ZERO_REG=1 -> read of 0 returns 0; sb_set to 0 -> rbusy 0.
REQ-035 SHALL cover: sb_set addr 9 -> read 9 gives rbusy=1; we1 to 9 -> rbusy=0; sb_set and we0 both on 9 same cycle -> rbusy=1.
REQ-036 SHALL cover: register 4 = 0x1234 and busy, assert rst one cycle -> read of 4 returns 0, rbusy 0.

Source files
------------

// File: rtl/candy_regfile_mp.sv
// Multi-port register file: two write ports, NUM_RD registered read ports with
// write-through forwarding, and a per-register busy scoreboard.
module candy_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr
);

  localparam int NREG = 2**ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_r [NREG];
  logic [NREG-1:0]   busy_r;
  logic [NREG-1:0]   busy_nxt_s;
  logic              wen0_s;
  logic              wen1_s;
  logic              sb_en_s;
  logic [ADDR_W-1:0] ra_s      [NUM_RD];
  logic [DATA_W-1:0] rd_val_s  [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_s;

  // Writes and scoreboard sets aimed at the hardwired zero register are dropped here.
  assign wen0_s  = we0 && !(ZR && (waddr0 == '0));
  assign wen1_s  = we1 && !(ZR && (waddr1 == '0));
  assign sb_en_s = sb_set && !(ZR && (sb_addr == '0));

  for (genvar j = 0; j < NREG; j++) begin : g_busy
    assign busy_nxt_s[j] =
        (sb_en_s && (sb_addr == ADDR_W'(j)))                 ? 1'b1 :
        ((wen0_s && (waddr0 == ADDR_W'(j))) ||
         (wen1_s && (waddr1 == ADDR_W'(j))))                 ? 1'b0 :
                                                               busy_r[j];
  end

  // Forwarding makes a read see the array as it will be after this edge.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign ra_s[i]      = raddr[i*ADDR_W +: ADDR_W];
    assign rd_val_s[i]  = (wen1_s && (waddr1 == ra_s[i])) ? wdata1 :
                          (wen0_s && (waddr0 == ra_s[i])) ? wdata0 :
                                                            regs_r[ra_s[i]];
    assign rd_busy_s[i] = busy_nxt_s[ra_s[i]];
  end

  // Register array, scoreboard and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NREG; j++) begin
        regs_r[j] <= '0;
      end
      busy_r <= '0;
      rdata  <= '0;
      rbusy  <= '0;
    end else begin
      if (wen0_s) begin
        regs_r[waddr0] <= wdata0;
      end
      if (wen1_s) begin
        regs_r[waddr1] <= wdata1;
      end
      busy_r <= busy_nxt_s;
      for (int i = 0; i < NUM_RD; i++) begin
        rdata[i*DATA_W +: DATA_W] <= re[i] ? rd_val_s[i] : {DATA_W{1'b0}};
        rbusy[i]                  <= re[i] & rd_busy_s[i];
      end
    end
  end

endmodule

// File: tb/tb_candy_regfile_mp.sv
// Bench for candy_regfile_mp: directed vector table, short corner sequence,
// then random traffic against a post-update array/scoreboard model.
module tb_candy_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        sb_set;
  logic [4:0]  sb_addr;

  int checks = 0;
  int errors = 0;

  candy_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we0(we0), .we1(we1),
    .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .sb_set(sb_set), .sb_addr(sb_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        we0;  logic [4:0] wa0; logic [31:0] wd0;
    logic        we1;  logic [4:0] wa1; logic [31:0] wd1;
    logic        sb;   logic [4:0] sa;
    logic [1:0]  re;   logic [4:0] ra0; logic [4:0] ra1;
    logic [31:0] e0;   logic [31:0] e1; logic [1:0] eb;
  } vec_t;

  function automatic vec_t mk(input logic r,
                              input logic we0_i, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic we1_i, input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic sb, input logic [4:0] sa,
                              input logic [1:0] re_i, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    vec_t v;
    v.r = r; v.we0 = we0_i; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1_i; v.wa1 = wa1; v.wd1 = wd1; v.sb = sb; v.sa = sa;
    v.re = re_i; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  // Reference model: the register file as arrays, read after this cycle's updates.
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic [31:0] m_rd   [2];
  logic [1:0]  m_rb;

  task automatic model_step();
    logic [4:0] ra;
    if (rst) begin
      for (int k = 0; k < 32; k++) begin m_mem[k] = 32'd0; m_busy[k] = 1'b0; end
      m_rd[0] = 32'd0; m_rd[1] = 32'd0; m_rb = 2'b00;
    end else begin
      if (we0 && waddr0 != 5'd0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != 5'd0) m_mem[waddr1] = wdata1;
      if (we0) m_busy[waddr0] = 1'b0;
      if (we1) m_busy[waddr1] = 1'b0;
      if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        ra = raddr[i*5 +: 5];
        m_rd[i] = re[i] ? m_mem[ra] : 32'd0;
        m_rb[i] = re[i] ? m_busy[ra] : 1'b0;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0;
    we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1;
    sb_set = v.sb; sb_addr = v.sa; re = v.re; raddr = {v.ra1, v.ra0};
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive(v);
    check({tag, "_rdata0"}, rdata[31:0], v.e0);
    check({tag, "_rdata1"}, rdata[63:32], v.e1);
    check({tag, "_rbusy"}, {30'd0, rbusy}, {30'd0, v.eb});
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; waddr0 = 5'd0; waddr1 = 5'd0;
    wdata0 = 32'd0; wdata1 = 32'd0; re = 2'b00; raddr = 10'd0;
    sb_set = 1'b0; sb_addr = 5'd0;

    //            r  we0 wa0   wd0           we1 wa1   wd1           sb  sa    re     ra0   ra1   e0            e1            eb
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b11, 5'd1, 5'd3, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00));
    tbl.push_back(mk(0, 1, 5'd7, 32'h11,       1, 5'd7, 32'h22,       0, 5'd0, 2'b01, 5'd7, 5'd0, 32'h22,       32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b10, 5'd0, 5'd7, 32'h0,        32'h22,       2'b00));
    tbl.push_back(mk(0, 1, 5'd0, 32'h55,       0, 5'd0, 32'h0,        0, 5'd0, 2'b01, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd0, 2'b11, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 2'b01, 5'd9, 5'd0, 32'h0,        32'h0,        2'b01));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b11, 5'd9, 5'd9, 32'h0,        32'h0,        2'b11));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd9, 32'hA5A5,     0, 5'd0, 2'b01, 5'd9, 5'd0, 32'hA5A5,     32'h0,        2'b00));
    tbl.push_back(mk(0, 1, 5'd9, 32'h77,       0, 5'd0, 32'h0,        1, 5'd9, 2'b01, 5'd9, 5'd0, 32'h77,       32'h0,        2'b01));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b00, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 1, 5'd4, 32'h1234,     0, 5'd0, 32'h0,        1, 5'd4, 2'b01, 5'd4, 5'd0, 32'h1234,     32'h0,        2'b01));
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        1, 5'd4, 32'hFFFF,     1, 5'd6, 2'b01, 5'd4, 5'd0, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b11, 5'd4, 5'd6, 32'h0,        32'h0,        2'b00));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 2'b11, 5'd9, 5'd7, 32'h0,        32'h0,        2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("row%0d", i), tbl[i]);
    end

    // Busy persists across idle cycles, then a write clears it while forwarding data.
    run_vec("seq_set12",  mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 5'd12, 2'b00, 5'd12, 5'd0,  32'h0,        32'h0,        2'b00));
    run_vec("seq_idle",   mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00));
    run_vec("seq_rd12",   mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  2'b01, 5'd12, 5'd0,  32'h0,        32'h0,        2'b01));
    run_vec("seq_wr12",   mk(0, 1, 5'd12, 32'hCAFE0001, 0, 5'd0, 32'h0,        0, 5'd0,  2'b11, 5'd12, 5'd12, 32'hCAFE0001, 32'hCAFE0001, 2'b00));
    run_vec("seq_both3",  mk(0, 1, 5'd3,  32'h1,        1, 5'd3, 32'h0BADF00D, 1, 5'd3,  2'b10, 5'd0,  5'd3,  32'h0,        32'h0BADF00D, 2'b10));
    run_vec("seq_rd3",    mk(0, 0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  2'b11, 5'd3,  5'd12, 32'h0BADF00D, 32'hCAFE0001, 2'b01));

    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 49) == 0);
      we0     = 1'($urandom_range(0, 1));
      we1     = 1'($urandom_range(0, 1));
      waddr0  = 5'($urandom_range(0, 7));
      waddr1  = 5'($urandom_range(0, 7));
      wdata0  = $urandom;
      wdata1  = $urandom;
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = 5'($urandom_range(0, 7));
      re      = 2'($urandom_range(0, 3));
      raddr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      model_step();
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_rdata0", n), rdata[31:0], m_rd[0]);
      check($sformatf("rnd%0d_rdata1", n), rdata[63:32], m_rd[1]);
      check($sformatf("rnd%0d_rbusy", n), {30'd0, rbusy}, {30'd0, m_rb});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
